// File: rtl/axi_master_arbiter.sv
// axi_master_arbiter
//
// Shares one AXI3 master port between N internal requesters
// (0 = icache, 1 = dcache, 2 = uncached data). The read (AR/R) and write
// (AW/W/B) paths have independent FSMs, and each path allows one
// outstanding transaction. Burst, lock, cache and prot are tied off at the
// top level, so they do not appear here.
//
// Build option: define AXI_ARB_RR_EN for round-robin arbitration on each
// channel. The search starts after the last grant. Without it, the lowest
// index wins and there is no pointer state.
//
// Ports (N requesters, payload slice i of a packed bus at [W*i +: W]):
//   clk, rst                  clock, synchronous active-high reset
//   m_arvalid/m_ar/m_arready  requester AR: {arid,araddr,arlen,arsize}, 43b
//   m_r/m_rvalid/m_rready     R to requesters: broadcast payload, steered valid
//   m_awvalid/m_aw/m_awready  requester AW: {awid,awaddr,awlen,awsize}, 43b
//   m_w/m_wvalid/m_wready     requester W: {wdata,wstrb,wlast}, 37b
//   m_bresp/m_bvalid/m_bready B to requesters: broadcast resp, steered valid
//   s_ar*/s_r*/s_aw*/s_w*/s_b* the single slave-side AXI port
//
// Read FSM
//   state  | meaning
//   R_IDLE | arbitrating; the winner sees m_arready in this cycle
//   R_ADDR | s_arvalid held with the latched payload until s_arready
//   R_DATA | R beats steered to rg; leave on the rlast handshake
// Write FSM
//   state  | meaning
//   W_IDLE | arbitrating; the winner sees m_awready in this cycle
//   W_ADDR | s_awvalid held until s_awready; W is not forwarded yet
//   W_DATA | W beats from wg forwarded; leave on the wlast handshake
//   W_RESP | B steered to wg; leave on the B handshake

module axi_master_arbiter #(
   parameter int N = 3
) (
   input  logic            clk,
   input  logic            rst,
   input  logic [N-1:0]    m_arvalid,
   input  logic [43*N-1:0] m_ar,
   output logic [N-1:0]    m_arready,
   output logic [38:0]     m_r,
   output logic [N-1:0]    m_rvalid,
   input  logic [N-1:0]    m_rready,
   input  logic [N-1:0]    m_awvalid,
   input  logic [43*N-1:0] m_aw,
   output logic [N-1:0]    m_awready,
   input  logic [37*N-1:0] m_w,
   input  logic [N-1:0]    m_wvalid,
   output logic [N-1:0]    m_wready,
   output logic [1:0]      m_bresp,
   output logic [N-1:0]    m_bvalid,
   input  logic [N-1:0]    m_bready,
   output logic [42:0]     s_ar,
   output logic            s_arvalid,
   input  logic            s_arready,
   input  logic [38:0]     s_r,
   input  logic            s_rvalid,
   output logic            s_rready,
   output logic [42:0]     s_aw,
   output logic            s_awvalid,
   input  logic            s_awready,
   output logic [36:0]     s_w,
   output logic            s_wvalid,
   input  logic            s_wready,
   input  logic [1:0]      s_bresp,
   input  logic            s_bvalid,
   output logic            s_bready
);

   localparam int IW = (N > 1) ? $clog2(N) : 1;

   typedef enum logic [1:0] {R_IDLE, R_ADDR, R_DATA} r_state_t;
   typedef enum logic [1:0] {W_IDLE, W_ADDR, W_DATA, W_RESP} w_state_t;

   r_state_t      r_state;
   w_state_t      w_state;
   logic [IW-1:0] rg, wg;
   logic [N-1:0]  rg_oh, wg_oh;
   logic [N-1:0]  ar_elig, aw_elig;
   logic [IW-1:0] ar_win, aw_win;
   logic          ar_go, aw_go;

   function automatic logic [N-1:0] onehot(input logic [IW-1:0] idx);
      logic [N-1:0] oh;
      oh = '0;
      for (int i = 0; i < N; i++)
         if (idx == IW'(i)) oh[i] = 1'b1;
      return oh;
   endfunction

   function automatic logic [42:0] sel43(input logic [43*N-1:0] bus, input logic [IW-1:0] idx);
      logic [42:0] v;
      v = '0;
      for (int i = 0; i < N; i++)
         if (idx == IW'(i)) v = bus[43*i +: 43];
      return v;
   endfunction

   function automatic logic [36:0] sel37(input logic [37*N-1:0] bus, input logic [IW-1:0] idx);
      logic [36:0] v;
      v = '0;
      for (int i = 0; i < N; i++)
         if (idx == IW'(i)) v = bus[37*i +: 37];
      return v;
   endfunction

`ifdef AXI_ARB_RR_EN
   logic [IW-1:0] ar_ptr, aw_ptr;

   // Pick the requester closest after the last grant, cyclically.
   function automatic logic [IW-1:0] pick(input logic [N-1:0] req, input logic [IW-1:0] last);
      logic [IW-1:0] win;
      int            best;
      int            d;
      win  = '0;
      best = N;
      for (int i = 0; i < N; i++) begin
         d = (i + N - 1 - int'(last)) % N;
         if (req[i] && d < best) begin
            best = d;
            win  = IW'(i);
         end
      end
      return win;
   endfunction

   assign ar_win = pick(ar_elig, ar_ptr);
   assign aw_win = pick(aw_elig, aw_ptr);
`else
   function automatic logic [IW-1:0] pick(input logic [N-1:0] req);
      logic [IW-1:0] win;
      win = '0;
      for (int i = N - 1; i >= 0; i--)
         if (req[i]) win = IW'(i);
      return win;
   endfunction

   assign ar_win = pick(ar_elig);
   assign aw_win = pick(aw_elig);
`endif

   assign rg_oh = onehot(rg);
   assign wg_oh = onehot(wg);

   // A requester with a write in flight may not start a read. This keeps a
   // dcache writeback ahead of its own refill of the same line.
   assign ar_elig = m_arvalid & ~((w_state != W_IDLE) ? wg_oh : '0);
   assign aw_elig = m_awvalid;

   assign ar_go = !rst && (r_state == R_IDLE) && (|ar_elig);
   assign aw_go = !rst && (w_state == W_IDLE) && (|aw_elig);

   assign m_arready = ar_go ? onehot(ar_win) : '0;
   assign m_awready = aw_go ? onehot(aw_win) : '0;

   // Response payloads are broadcast; only the valid/ready bits are steered.
   assign m_r      = s_r;
   assign m_bresp  = s_bresp;
   assign m_rvalid = (r_state == R_DATA && s_rvalid) ? rg_oh : '0;
   assign s_rready = (r_state == R_DATA) && (|(m_rready & rg_oh));

   assign s_w      = (w_state == W_DATA) ? sel37(m_w, wg) : '0;
   assign s_wvalid = (w_state == W_DATA) && (|(m_wvalid & wg_oh));
   assign m_wready = (w_state == W_DATA && s_wready) ? wg_oh : '0;
   assign m_bvalid = (w_state == W_RESP && s_bvalid) ? wg_oh : '0;
   assign s_bready = (w_state == W_RESP) && (|(m_bready & wg_oh));

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state   <= R_IDLE;
         rg        <= '0;
         s_ar      <= '0;
         s_arvalid <= 1'b0;
`ifdef AXI_ARB_RR_EN
         ar_ptr    <= IW'(N - 1);
`endif
      end else begin
         case (r_state)
            R_IDLE: if (ar_go) begin
               rg        <= ar_win;
               s_ar      <= sel43(m_ar, ar_win);
               s_arvalid <= 1'b1;
               r_state   <= R_ADDR;
`ifdef AXI_ARB_RR_EN
               ar_ptr    <= ar_win;
`endif
            end
            R_ADDR: if (s_arready) begin
               s_arvalid <= 1'b0;
               r_state   <= R_DATA;
            end
            R_DATA: if (s_rvalid && s_rready && s_r[0]) r_state <= R_IDLE;
            default: r_state <= R_IDLE;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         w_state   <= W_IDLE;
         wg        <= '0;
         s_aw      <= '0;
         s_awvalid <= 1'b0;
`ifdef AXI_ARB_RR_EN
         aw_ptr    <= IW'(N - 1);
`endif
      end else begin
         case (w_state)
            W_IDLE: if (aw_go) begin
               wg        <= aw_win;
               s_aw      <= sel43(m_aw, aw_win);
               s_awvalid <= 1'b1;
               w_state   <= W_ADDR;
`ifdef AXI_ARB_RR_EN
               aw_ptr    <= aw_win;
`endif
            end
            W_ADDR: if (s_awready) begin
               s_awvalid <= 1'b0;
               w_state   <= W_DATA;
            end
            W_DATA: if (s_wvalid && s_wready && s_w[0]) w_state <= W_RESP;
            W_RESP: if (s_bvalid && s_bready) w_state <= W_IDLE;
            default: w_state <= W_IDLE;
         endcase
      end
   end

endmodule
